fir_out_decimator: RTL and testbench

- Sits directly downstream of the parametrized FIR filter. Consumes its full-precision output, one sample per clock.
- Keeps every DECIM-th sample, then rescales it with an arithmetic right shift and round-half-up, and saturates it to DATA_WIDTH.
- Buffers results in a small first-word-fall-through FIFO behind a valid/ready handshake toward the next consumer.
- Flags saturation and dropped samples with sticky status bits.

---
 rtl/fir_out_decimator.sv | 103 ++++++++++
 tb/tb_fir_out_decimator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: keep every DECIM-th FIR sample, round/shift/saturate it into a FWFT FIFO with sticky flags.
// Define FIR_DEC_DROP_CNT_EN to add the saturating o_drop_cnt dropped-sample counter.
module fir_out_decimator #(
  parameter int DATA_WIDTH        = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int DECIM             = 4,
  parameter int SHIFT             = 15,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_WIDTH+COEFFICIENT_WIDTH-1:0]   i_sig,
  input  logic                                      i_valid,
  input  logic                                      i_sync,
  input  logic                                      i_clr,
  output logic [DATA_WIDTH-1:0]                     o_sig,
  output logic                                      o_valid,
  input  logic                                      o_ready,
  output logic                                      o_ovf,
  output logic                                      o_drop
`ifdef FIR_DEC_DROP_CNT_EN
  , output logic [15:0]                             o_drop_cnt
`endif
);
  localparam int W  = DATA_WIDTH + COEFFICIENT_WIDTH;
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DECIM - 1);
  localparam logic signed [W:0] MAXV = {{(W-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [W:0] MINV = {{(W-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic [PW-1:0] r_ph, w_ph_base;
  logic w_keep;
  assign w_keep    = i_valid & (i_sync | (r_ph == '0));
  assign w_ph_base = i_sync ? '0 : r_ph;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_ph <= '0;
    else if (i_valid) r_ph <= (w_ph_base == PLAST) ? '0 : w_ph_base + PW'(1);
    else r_ph <= w_ph_base;
  // one guard bit so the rounding offset can never wrap the sum
  logic signed [W:0] w_ext, w_sum, w_r;
  logic w_hi, w_lo;
  logic [DATA_WIDTH-1:0] w_d;
  assign w_ext = {i_sig[W-1], i_sig};
  generate
    if (SHIFT == 0) begin : g_ns
      assign w_sum = w_ext;
    end else begin : g_sh
      assign w_sum = w_ext + ((W+1)'(1) << (SHIFT - 1));
    end
  endgenerate
  assign w_r  = w_sum >>> SHIFT;
  assign w_hi = w_r > MAXV;
  assign w_lo = w_r < MINV;
  assign w_d  = w_hi ? MAXV[DATA_WIDTH-1:0] : w_lo ? MINV[DATA_WIDTH-1:0] : w_r[DATA_WIDTH-1:0];
  logic r_s1_valid, r_s1_sat;
  logic [DATA_WIDTH-1:0] r_s1_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_keep;
      r_s1_sat   <= w_hi | w_lo;
      r_s1_data  <= w_d;
    end
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_full, w_rd, w_wr, w_drop;
  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign w_rd   = o_valid & o_ready;
  assign w_wr   = r_s1_valid & (~w_full | w_rd);
  assign w_drop = r_s1_valid & w_full & ~w_rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_wr);
      r_rp  <= r_rp + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= r_s1_data;
  // gating by o_valid gives o_sig=0 when empty without resetting the storage
  assign o_valid = r_cnt != '0;
  assign o_sig   = o_valid ? r_mem[r_rp] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_ovf  <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      o_ovf  <= (w_wr & r_s1_sat) | (o_ovf & ~i_clr);
      o_drop <= w_drop | (o_drop & ~i_clr);
    end
`ifdef FIR_DEC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) o_drop_cnt <= '0;
    else o_drop_cnt <= i_clr ? {15'd0, w_drop} : (w_drop && o_drop_cnt != 16'hFFFF) ? o_drop_cnt + 16'd1 : o_drop_cnt;
`endif
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb_fir_out_decimator: randomized and directed stimulus checked against a queue-based reference model.
module tb_fir_out_decimator;
  localparam int DEC = 4, SH = 15, FD = 4;
  logic clk = 0, rst = 0;
  logic [31:0] i_sig = 0;
  logic i_valid = 0, i_sync = 0, i_clr = 0, o_ready = 0;
  logic [15:0] o_sig;
  logic o_valid, o_ovf, o_drop;
`ifdef FIR_DEC_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  fir_out_decimator #(.DATA_WIDTH(16), .COEFFICIENT_WIDTH(16), .DECIM(DEC), .SHIFT(SH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .i_sig(i_sig), .i_valid(i_valid), .i_sync(i_sync), .i_clr(i_clr),
    .o_sig(o_sig), .o_valid(o_valid), .o_ready(o_ready), .o_ovf(o_ovf), .o_drop(o_drop)
`ifdef FIR_DEC_DROP_CNT_EN
    , .o_drop_cnt(o_drop_cnt)
`endif
  );

  int ph, m_cnt;
  bit m_s1v, m_s1s, m_ovf, m_drop;
  logic [15:0] m_s1d;
  logic [15:0] q[$];

  function automatic logic [16:0] scale(input logic [31:0] x);
    longint v = longint'($signed(x));
    if (SH > 0) v = (v + (longint'(1) << (SH - 1))) >>> SH;
    if (v > 32767) return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  task automatic model_reset();
    ph = 0; m_s1v = 0; m_s1s = 0; m_s1d = 0; q.delete(); m_ovf = 0; m_drop = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit rd, wr, dr;
    logic [16:0] s;
    if (!rst) begin model_reset(); return; end
    rd = q.size() != 0 && o_ready;
    wr = m_s1v && (q.size() < FD || rd);
    dr = m_s1v && !wr;
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(m_s1d);
    m_ovf  = (wr && m_s1s) || (m_ovf && !i_clr);
    m_drop = dr || (m_drop && !i_clr);
    m_cnt  = i_clr ? int'(dr) : (dr && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    m_s1v  = i_valid && (i_sync || ph == 0);
    s = scale(i_sig);
    m_s1d = s[15:0];
    m_s1s = s[16];
    if (i_valid) ph = i_sync ? 1 % DEC : (ph + 1) % DEC;
    else if (i_sync) ph = 0;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_all();
    chk("o_valid", o_valid, q.size() != 0);
    chk("o_sig", o_sig, q.size() != 0 ? q[0] : 16'h0);
    chk("o_ovf", o_ovf, m_ovf);
    chk("o_drop", o_drop, m_drop);
`ifdef FIR_DEC_DROP_CNT_EN
    chk("o_drop_cnt", o_drop_cnt, m_cnt);
`endif
  endtask

  task automatic cyc(input bit v, input logic [31:0] x, input bit s, input bit c, input bit r);
    i_valid = v; i_sig = x; i_sync = s; i_clr = c; o_ready = r;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic one(input string n, input logic [31:0] x, input logic [15:0] e);
    cyc(1, x, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk({n, "_v"}, o_valid, 1);
    chk(n, o_sig, e);
  endtask

  int ev[7] = '{0, 1, 1, 0, 0, 0, 1};
  int es[7] = '{0, 21, 22, 0, 0, 0, 26};
  int x;

  initial begin
    model_reset();
    repeat (2) cyc(0, 0, 0, 0, 1);
    #2 rst = 1;
    for (int k = 0; k < 8; k++) begin
      cyc(1, k * 32768, 0, 0, 1);
      if (k == 1) begin chk("dec0_v", o_valid, 1); chk("dec0", o_sig, 0); end
      if (k == 5) begin chk("dec4_v", o_valid, 1); chk("dec4", o_sig, 4); end
    end
    repeat (2) cyc(0, 0, 0, 0, 1);
    one("rnd_p16384", 16384, 16'h0001);
    one("rnd_p16383", 16383, 16'h0000);
    one("rnd_m16384", -16384, 16'h0000);
    one("rnd_m16385", -16385, 16'hFFFF);
    chk("ovf_nosat", o_ovf, 0);
    one("sat_hi", 32'h4000_0000, 16'h7FFF);
    chk("ovf_hi", o_ovf, 1);
    cyc(0, 0, 0, 1, 1);
    chk("ovf_clr", o_ovf, 0);
    one("sat_lo", 32'h8000_0000, 16'h8000);
    chk("ovf_lo", o_ovf, 1);
    cyc(0, 0, 0, 1, 1);
    chk("ovf_clr2", o_ovf, 0);
    for (int j = 1; j <= 6; j++) cyc(1, j * 32768, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("bp_drop", o_drop, 1);
`ifdef FIR_DEC_DROP_CNT_EN
    chk("bp_drop_cnt", o_drop_cnt, 2);
`endif
    for (int j = 1; j <= 4; j++) begin
      chk("bp_order", o_sig, j);
      cyc(0, 0, 0, 0, 1);
    end
    chk("bp_empty", o_valid, 0);
    cyc(0, 0, 0, 1, 1);
    for (int j = 10; j <= 14; j++) cyc(1, j * 32768, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("fr_nodrop", o_drop, 0);
    for (int j = 11; j <= 14; j++) begin
      chk("fr_order", o_sig, j);
      cyc(0, 0, 0, 0, 1);
    end
    chk("fr_empty", o_valid, 0);
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, (21 + i) * 32768, i == 1, 0, 1);
      chk("sync_v", o_valid, ev[i]);
      if (ev[i] != 0) chk("sync_sig", o_sig, es[i]);
    end
    repeat (3000) begin
      case ($urandom_range(0, 2))
        0: x = int'($urandom);
        1: x = int'($urandom_range(0, 2097152)) - 1048576;
        default: x = (int'($urandom_range(0, 200)) - 100) * 32768 + 16384 - int'($urandom_range(0, 1));
      endcase
      cyc($urandom_range(0, 9) < 7, x, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    repeat (6) cyc(1, 3 * 32768, 1, 0, 0);
    #2 rst = 0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_sig", o_sig, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_drop", o_drop, 0);
`ifdef FIR_DEC_DROP_CNT_EN
    chk("rst_drop_cnt", o_drop_cnt, 0);
`endif
    model_reset();
    cyc(0, 0, 0, 0, 0);
    #2 rst = 1;
    cyc(1, 7 * 32768, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_first_v", o_valid, 1);
    chk("rst_first", o_sig, 7);
    cyc(0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
